// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit core: opcode map, sequencer states and format helper.
package cpu_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_XOR   = 4'h5;
    localparam logic [3:0] OP_LDI   = 4'h6;
    localparam logic [3:0] OP_ADDI  = 4'h7;
    localparam logic [3:0] OP_LD    = 4'h8;
    localparam logic [3:0] OP_ST    = 4'h9;
    localparam logic [3:0] OP_JMP   = 4'hA;
    localparam logic [3:0] OP_BEQ   = 4'hB;
    localparam logic [3:0] OP_BNE   = 4'hC;
    localparam logic [3:0] OP_RSV_D = 4'hD;
    localparam logic [3:0] OP_RSV_E = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StWb     = 3'd3,
        StMem    = 3'd4,
        StBranch = 3'd5,
        StHalt   = 3'd6
    } state_e;

    // Opcodes whose low nibble is a signed 4-bit immediate.
    function automatic logic is_imm4(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_ADDI) || (op == OP_JMP) ||
               (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter: reset load, +1 after each fetch, relative add for taken branches.
// All arithmetic wraps modulo 2^ADDR_W.
module pc_unit #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              take,
    input  logic [7:0]        offset,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] off_ext;

    // Sign-extend the 8-bit branch offset to the PC width.
    always_comb begin
        off_ext = ADDR_W'($signed(offset));
    end

    // PC register; increment and branch never coincide (different FSM states).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= ADDR_W'(RESET_PC);
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end else if (take) begin
            pc <= pc + off_ext;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM for the 8-bit core: fetch, decode, execute/memory/branch, write-back.
// All strobes and requests are flops so they come straight off registers.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [7:0]        imem_rdata,
    output logic [7:0]        ir,
    output logic              isim4,
    input  logic [3:0]        opcode,
    input  logic [7:0]        imm8,
    input  logic              zero_flag,
    output logic              alu_en,
    output logic              reg_we,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    state_e state;
    logic   pc_inc;
    logic   br_take;

    // Decoder format select and PC-unit controls.
    always_comb begin
        isim4   = is_imm4(ir[7:4]);
        pc_inc  = (state == StFetch) && imem_req && imem_ack;
        br_take = (state == StBranch) &&
                  ((opcode == OP_JMP) ||
                   ((opcode == OP_BEQ) && zero_flag) ||
                   ((opcode == OP_BNE) && !zero_flag));
    end

    assign imem_addr = pc;

    pc_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (pc_inc),
        .take   (br_take),
        .offset (imm8),
        .pc     (pc)
    );

    // Sequencer FSM with registered outputs. imem_req is clear in reset, so the first
    // cycle after reset raises it; every later entry to FETCH raises it on the transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StFetch;
            ir       <= 8'h00;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            alu_en   <= 1'b0;
            reg_we   <= 1'b0;
            halted   <= 1'b0;
        end else begin
            alu_en <= 1'b0;
            reg_we <= 1'b0;
            unique case (state)
                StFetch: begin
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= StDecode;
                    end
                end
                StDecode: begin
                    case (opcode)
                        OP_NOP, OP_RSV_D, OP_RSV_E: begin
                            imem_req <= 1'b1;
                            state    <= StFetch;
                        end
                        OP_HALT: begin
                            halted <= 1'b1;
                            state  <= StHalt;
                        end
                        OP_LD, OP_ST: begin
                            dmem_req <= 1'b1;
                            dmem_we  <= (opcode == OP_ST);
                            state    <= StMem;
                        end
                        OP_JMP, OP_BEQ, OP_BNE: begin
                            state <= StBranch;
                        end
                        default: begin
                            alu_en <= 1'b1;
                            state  <= StExec;
                        end
                    endcase
                end
                StExec: begin
                    reg_we <= 1'b1;
                    state  <= StWb;
                end
                StWb: begin
                    imem_req <= 1'b1;
                    state    <= StFetch;
                end
                StMem: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (dmem_we) begin
                            imem_req <= 1'b1;
                            state    <= StFetch;
                        end else begin
                            reg_we <= 1'b1;
                            state  <= StWb;
                        end
                    end
                end
                StBranch: begin
                    imem_req <= 1'b1;
                    state    <= StFetch;
                end
                StHalt: begin
                    state <= StHalt;
                end
                default: begin
                    imem_req <= 1'b1;
                    state    <= StFetch;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: an instruction-level model expands each instruction into the
// per-cycle output trace it must produce; every cycle the DUT outputs are compared to it.
module tb_instr_sequencer;

    logic       clk;
    logic       rst_n;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic [7:0] ir;
    logic       isim4;
    logic [3:0] opcode;
    logic [7:0] imm8;
    logic       zero_flag;
    logic       alu_en;
    logic       reg_we;
    logic       dmem_req;
    logic       dmem_we;
    logic       dmem_ack;
    logic [7:0] pc;
    logic       halted;

    int n_cmp;
    int n_fail;

    // Stand-in for the instruction Decoder.
    assign opcode = ir[7:4];
    assign imm8   = {{4{ir[3]}}, ir[3:0]};

    instr_sequencer #(
        .ADDR_W   (8),
        .RESET_PC (0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .isim4      (isim4),
        .opcode     (opcode),
        .imm8       (imm8),
        .zero_flag  (zero_flag),
        .alu_en     (alu_en),
        .reg_we     (reg_we),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .pc         (pc),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       imem_req;
        logic [7:0] imem_addr;
        logic [7:0] ir;
        logic       isim4;
        logic       alu_en;
        logic       reg_we;
        logic       dmem_req;
        logic       dmem_we;
        logic [7:0] pc;
        logic       halted;
    } obs_t;

    // Architectural model state.
    logic [7:0] m_pc;
    logic [7:0] m_ir;
    logic       m_halted;

    function automatic logic rnd1();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [7:0] rnd8();
        return 8'($urandom);
    endfunction

    function automatic logic imm_fmt(input logic [3:0] op);
        return op inside {4'h6, 4'h7, 4'hA, 4'hB, 4'hC};
    endfunction

    // Quiet cycle: no strobes, no requests.
    function automatic obs_t base();
        obs_t e;
        e = '0;
        e.imem_addr = m_pc;
        e.pc        = m_pc;
        e.ir        = m_ir;
        e.isim4     = imm_fmt(m_ir[7:4]);
        e.halted    = m_halted;
        return e;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("ireq=%b addr=%h ir=%h im4=%b alu=%b rwe=%b dreq=%b dwe=%b pc=%h halt=%b",
                         o.imem_req, o.imem_addr, o.ir, o.isim4, o.alu_en, o.reg_we,
                         o.dmem_req, o.dmem_we, o.pc, o.halted);
    endfunction

    // One cycle: at the falling edge compare outputs, then drive this cycle's inputs.
    task automatic step(input string tag, input obs_t exp, input logic iack,
                        input logic [7:0] rdata, input logic dack, input logic zf);
        obs_t act;
        @(negedge clk);
        act.imem_req  = imem_req;
        act.imem_addr = imem_addr;
        act.ir        = ir;
        act.isim4     = isim4;
        act.alu_en    = alu_en;
        act.reg_we    = reg_we;
        act.dmem_req  = dmem_req;
        act.dmem_we   = dmem_we;
        act.pc        = pc;
        act.halted    = halted;
        if (!exp.dmem_req) begin
            act.dmem_we = 1'b0;
            exp.dmem_we = 1'b0;
        end
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got {%s} required {%s}", tag, $time, fmt(act), fmt(exp));
        end
        imem_ack   = iack;
        imem_rdata = rdata;
        dmem_ack   = dack;
        zero_flag  = zf;
    endtask

    task automatic check_lit(input string tag, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", tag, act, req);
        end
    endtask

    task automatic do_reset();
        obs_t e;
        rst_n    = 1'b0;
        m_pc     = 8'h00;
        m_ir     = 8'h00;
        m_halted = 1'b0;
        e = base();
        step("reset", e, rnd1(), rnd8(), rnd1(), rnd1());
        rst_n = 1'b1;
    endtask

    // Run one instruction. fw/mw: wait cycles before imem/dmem ack; zsel<0 means random flag.
    task automatic run_instr(input logic [7:0] instr, input int fw, input int mw,
                             input int zsel);
        obs_t       e;
        logic [3:0] op;
        logic       zf;
        op = instr[7:4];
        for (int i = 0; i < fw; i++) begin
            e = base();
            e.imem_req = 1'b1;
            step("fetch_wait", e, 1'b0, rnd8(), rnd1(), rnd1());
        end
        e = base();
        e.imem_req = 1'b1;
        step("fetch", e, 1'b1, instr, rnd1(), rnd1());
        m_ir = instr;
        m_pc = m_pc + 8'd1;
        e = base();
        step("decode", e, rnd1(), rnd8(), rnd1(), rnd1());
        case (op)
            4'h0, 4'hD, 4'hE: begin
            end
            4'hF: begin
                m_halted = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    e = base();
                    step("halt", e, rnd1(), rnd8(), rnd1(), rnd1());
                end
            end
            4'h8, 4'h9: begin
                for (int i = 0; i < mw; i++) begin
                    e = base();
                    e.dmem_req = 1'b1;
                    e.dmem_we  = (op == 4'h9);
                    step("mem_wait", e, rnd1(), rnd8(), 1'b0, rnd1());
                end
                e = base();
                e.dmem_req = 1'b1;
                e.dmem_we  = (op == 4'h9);
                step("mem_ack", e, rnd1(), rnd8(), 1'b1, rnd1());
                if (op == 4'h8) begin
                    e = base();
                    e.reg_we = 1'b1;
                    step("ld_wb", e, rnd1(), rnd8(), rnd1(), rnd1());
                end
            end
            4'hA, 4'hB, 4'hC: begin
                zf = (zsel < 0) ? rnd1() : (zsel != 0);
                e = base();
                step("branch", e, rnd1(), rnd8(), rnd1(), zf);
                if ((op == 4'hA) || ((op == 4'hB) && zf) || ((op == 4'hC) && !zf)) begin
                    m_pc = m_pc + {{4{instr[3]}}, instr[3:0]};
                end
            end
            default: begin
                e = base();
                e.alu_en = 1'b1;
                step("exec", e, rnd1(), rnd8(), rnd1(), rnd1());
                e = base();
                e.reg_we = 1'b1;
                step("wb", e, rnd1(), rnd8(), rnd1(), rnd1());
            end
        endcase
    endtask

    // Look at the registered state just after the next rising edge.
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t       e;
        logic [7:0] instr;
        n_cmp      = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 8'h00;
        dmem_ack   = 1'b0;
        zero_flag  = 1'b0;

        // ADD: fetch, decode, exec, wb.
        do_reset();
        run_instr(8'h15, 0, 0, -1);
        settle();
        check_lit("add_pc", pc, 8'h01);
        check_lit("add_ir", ir, 8'h15);

        // LDI -1 with one fetch wait.
        run_instr(8'h6F, 1, 0, -1);
        settle();
        check_lit("ldi_isim4", {7'd0, isim4}, 8'h01);

        // BEQ -2 at address 4, taken and not taken.
        do_reset();
        repeat (4) run_instr(8'h00, 0, 0, -1);
        run_instr(8'hBE, 0, 0, 1);
        settle();
        check_lit("beq_taken_addr", imem_addr, 8'h03);
        do_reset();
        repeat (4) run_instr(8'h00, 0, 0, -1);
        run_instr(8'hBE, 0, 0, 0);
        settle();
        check_lit("beq_not_taken_addr", imem_addr, 8'h05);

        // LD with three dmem wait cycles, then ST.
        run_instr(8'h81, 0, 3, -1);
        run_instr(8'h92, 2, 1, -1);

        // PC wrap by increment: JMP -8 from 0 lands at F9, seven NOPs reach 00.
        do_reset();
        run_instr(8'hA8, 0, 0, -1);
        settle();
        check_lit("jmp_back_pc", pc, 8'hF9);
        repeat (6) run_instr(8'h00, 0, 0, -1);
        run_instr(8'h00, 0, 0, -1);
        settle();
        check_lit("nop_wrap_addr", imem_addr, 8'h00);

        // Branch-target wrap: JMP +7 at FB -> 03.
        do_reset();
        run_instr(8'hA8, 0, 0, -1);
        repeat (2) run_instr(8'h00, 0, 0, -1);
        run_instr(8'hA7, 0, 0, -1);
        settle();
        check_lit("jmp_wrap_addr", imem_addr, 8'h03);

        // Reset in the middle of a load handshake.
        do_reset();
        e = base();
        e.imem_req = 1'b1;
        step("fetch", e, 1'b1, 8'h81, 1'b0, 1'b0);
        m_ir = 8'h81;
        m_pc = m_pc + 8'd1;
        e = base();
        step("decode", e, 1'b0, 8'h00, 1'b0, 1'b0);
        e = base();
        e.dmem_req = 1'b1;
        step("mem_wait", e, 1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_lit("midmem_dmem_req", {7'd0, dmem_req}, 8'h00);
        check_lit("midmem_pc", pc, 8'h00);
        do_reset();
        run_instr(8'h15, 0, 0, -1);

        // Randomized program with random wait states (HALT kept for the end).
        do_reset();
        for (int n = 0; n < 400; n++) begin
            instr = rnd8();
            if (instr[7:4] == 4'hF) begin
                instr[7:4] = 4'h0;
            end
            run_instr(instr, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), -1);
        end

        // HALT is terminal.
        run_instr(8'hF0, 1, 0, -1);
        check_lit("halted", {7'd0, halted}, 8'h01);
        do_reset();
        run_instr(8'h27, 0, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
